id_ex_stage: RTL

- ID→EX pipeline register sitting directly upstream of RISCVALU; produces its ALUctl, A and B inputs.
- Registers decoded control and operands each cycle and decodes ALUOp/funct into the 4-bit ALUctl.
- Applies EX/MEM and MEM/WB forwarding to the operands.
- Detects load-use hazards, inserts bubbles, and honours external stall/flush.

---
 rtl/id_ex_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// This is the ID->EX pipeline register that feeds the ALU. On each rising
// edge it captures the decoded instruction from ID. It turns ALUOp, funct3
// and funct7[5] into the 4-bit ALU control code. It also applies EX/MEM and
// MEM/WB forwarding to the registered operands.
//
// Flow control, in priority order on every edge:
//   reset > flush > stall > load_use_stall > capture.
// The priorities work as follows:
//   - flush and a load-use hazard both load a bubble (all fields zero).
//   - stall holds every field, with one exception: a MEM/WB write that
//     matches a held source register is written into the held operand.
//     A producer that retires during the stall therefore stays visible.
//   - capture has a latency of one cycle from the id_* inputs to the ex_*
//     outputs.
//   - load_use_stall is combinational. While it is high, upstream must hold
//     the PC and IF/ID.
//
// Ports
//   clk, reset                  rising-edge clock; synchronous active-high reset
//   id_valid, stall, flush      flow control
//   id_*                        decoded fields from ID
//   exmem_*, memwb_*            forwarding sources
//   ex_valid, ex_alu_ctl        registered valid flag and ALU control code
//   ex_a, ex_b, ex_store_data   forwarded operands
//   ex_rd, ex_reg_write,
//   ex_mem_read, ex_mem_write   registered destination index and control bits
//   load_use_stall              hazard request to upstream
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [1:0]      id_alu_op,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            id_alu_src,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_alu_out,
    input  logic            memwb_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_ctl,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_stall
);

    localparam logic [REGW-1:0] X0 = '0;

    // Registered EX fields
    logic            valid_q;
    logic [3:0]      alu_ctl_q;
    logic            alu_src_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [XLEN-1:0] rs2_val_q;
    logic [XLEN-1:0] imm_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [REGW-1:0] rd_q;
    logic            reg_write_q;
    logic            mem_read_q;
    logic            mem_write_q;

    // ALU control codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT
    function automatic logic [3:0] alu_decode(input logic [1:0] op,
                                              input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       src);
        logic [3:0] ctl;
        ctl = 4'd2;
        case (op)
            2'b00: ctl = 4'd2;
            2'b01: ctl = 4'd6;
            2'b10: begin
                case (f3)
                    // SUB exists only in register form; for addi, bit 30 is immediate bits
                    3'b000:  ctl = (f7b5 && !src) ? 4'd6 : 4'd2;
                    3'b111:  ctl = 4'd0;
                    3'b110:  ctl = 4'd1;
                    3'b010:  ctl = 4'd7;
                    default: ctl = 4'd2;
                endcase
            end
            default: ctl = 4'd2;
        endcase
        return ctl;
    endfunction

    // Matches against the registered source indices. x0 never matches.
    logic exmem_hit_rs1, exmem_hit_rs2, memwb_hit_rs1, memwb_hit_rs2;
    assign exmem_hit_rs1 = exmem_reg_write && (exmem_rd != X0) && (exmem_rd == rs1_q);
    assign exmem_hit_rs2 = exmem_reg_write && (exmem_rd != X0) && (exmem_rd == rs2_q);
    assign memwb_hit_rs1 = memwb_reg_write && (memwb_rd != X0) && (memwb_rd == rs1_q);
    assign memwb_hit_rs2 = memwb_reg_write && (memwb_rd != X0) && (memwb_rd == rs2_q);

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    always_comb begin
        fwd_rs1 = rs1_val_q;
        if (exmem_hit_rs1)      fwd_rs1 = exmem_alu_out;
        else if (memwb_hit_rs1) fwd_rs1 = memwb_wdata;
        fwd_rs2 = rs2_val_q;
        if (exmem_hit_rs2)      fwd_rs2 = exmem_alu_out;
        else if (memwb_hit_rs2) fwd_rs2 = memwb_wdata;
    end

    // A load in EX cannot forward its data until MEM, so any ID reader must
    // wait. rs2 counts as a reader when it feeds the ALU (register form) or
    // when it supplies store data.
    assign load_use_stall = id_valid && valid_q && mem_read_q && (rd_q != X0) &&
                            ((rd_q == id_rs1) ||
                             ((rd_q == id_rs2) && !id_alu_src) ||
                             ((rd_q == id_rs2) && id_mem_write));

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && load_use_stall)) begin
            valid_q     <= 1'b0;
            alu_ctl_q   <= 4'd0;
            alu_src_q   <= 1'b0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (stall) begin
            if (memwb_hit_rs1) rs1_val_q <= memwb_wdata;
            if (memwb_hit_rs2) rs2_val_q <= memwb_wdata;
        end else begin
            valid_q     <= id_valid;
            alu_ctl_q   <= id_valid ? alu_decode(id_alu_op, id_funct3, id_funct7b5, id_alu_src)
                                    : 4'd0;
            alu_src_q   <= id_alu_src;
            rs1_val_q   <= id_rs1_val;
            rs2_val_q   <= id_rs2_val;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            reg_write_q <= id_valid && id_reg_write;
            mem_read_q  <= id_valid && id_mem_read;
            mem_write_q <= id_valid && id_mem_write;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_ctl    = alu_ctl_q;
    assign ex_a          = fwd_rs1;
    assign ex_b          = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q && reg_write_q;
    assign ex_mem_read   = valid_q && mem_read_q;
    assign ex_mem_write  = valid_q && mem_write_q;

endmodule
